// File: rtl/pe_pkg.sv
// pe_pkg: shared types and constants for the PE array sequencer.
// Holds the sequencer state encoding and the drain-length helper.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;

    // Cycles from the last read until the bottom-right PE result is final
    function automatic int drain_len(
        input int rows,
        input int cols,
        input int read_lat,
        input int pe_lat
    );
        return read_lat + rows + cols - 1 + pe_lat;
    endfunction

endpackage

// File: rtl/skew_line.sv
// skew_line: fixed-depth delay line for one operand lane plus its valid bit.
// Output is forced to zero whenever the delayed valid is low.
module skew_line #(
    parameter int DEPTH = 0,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    if (DEPTH == 0) begin : g_pass
        logic w_unused;
        assign w_unused = ^{clk, rstn, i_flush};
        assign o_data   = i_valid ? i_data : '0;
    end else begin : g_dly
        logic [DEPTH-1:0]        r_v;
        logic [DEPTH-1:0][W-1:0] r_d;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_v <= '0;
                r_d <= '0;
            end else if (i_flush) begin
                r_v <= '0;
                r_d <= '0;
            end else begin
                r_v[0] <= i_valid;
                r_d[0] <= i_data;
                for (int k = 1; k < DEPTH; k++) begin
                    r_v[k] <= r_v[k-1];
                    r_d[k] <= r_d[k-1];
                end
            end
        end

        assign o_data = r_v[DEPTH-1] ? r_d[DEPTH-1] : '0;
    end

endmodule

// File: rtl/pe_arr_seq.sv
// pe_arr_seq: operand sequencer for the systolic PE array.
// Streams K skewed operand vectors into the array, then waits out the drain.
module pe_arr_seq
    import pe_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int KMAX     = 256,
    parameter int READ_LAT = 1,
    parameter int PE_LAT   = 1,
    parameter int AW       = $clog2(KMAX)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [AW:0]            k_len,
    input  logic                   abort,
    output logic                   rd_en,
    output logic [AW-1:0]          rd_addr,
    input  logic [DATA_W*COLS-1:0] w_rdata,
    input  logic [DATA_W*ROWS-1:0] a_rdata,
    output logic [DATA_W*COLS-1:0] w_bus,
    output logic [DATA_W*ROWS-1:0] a_bus,
    output logic                   fire,
    output logic                   acc_clr,
    output logic                   busy,
    output logic                   done
);

    localparam logic [AW:0] KMAX_C = (AW+1)'(KMAX);
    localparam logic [AW:0] DRAIN_M1 =
        (AW+1)'(drain_len(ROWS, COLS, READ_LAT, PE_LAT) - 1);

    state_t              r_state;
    state_t              w_next;
    logic [AW:0]         r_klen;
    logic [AW:0]         r_addr;
    logic [AW:0]         r_drain;
    logic [READ_LAT-1:0] r_vld;
    logic                w_busy;
    logic                w_flush;
    logic                w_last;
    logic                w_accept;
    logic                w_v0;

    assign w_busy   = (r_state == FEED) || (r_state == DRAIN);
    assign w_flush  = abort && w_busy;
    assign w_last   = (r_addr == r_klen - 1'b1);
    assign w_accept = (r_state == IDLE) && start && (k_len != '0);
    assign w_v0     = r_vld[READ_LAT-1];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = (k_len == '0) ? DONE : FEED;
            FEED:    if (w_last) w_next = DRAIN;
            DRAIN:   if (r_drain == '0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_flush) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_klen  <= '0;
            r_addr  <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_klen <= (k_len > KMAX_C) ? KMAX_C : k_len;
                r_addr <= '0;
            end else if (r_state == FEED) begin
                r_addr <= r_addr + 1'b1;
            end
            // Loaded with length-1 so DRAIN spans exactly drain_len cycles
            if (r_state == FEED && w_last) begin
                r_drain <= DRAIN_M1;
            end else if (r_state == DRAIN && r_drain != '0) begin
                r_drain <= r_drain - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
        end else if (w_flush) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= rd_en;
            for (int k = 1; k < READ_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    assign rd_en   = (r_state == FEED) && !abort;
    assign rd_addr = rd_en ? r_addr[AW-1:0] : '0;
    assign acc_clr = (r_state == FEED) && (r_addr == '0);
    assign fire    = w_v0;
    assign busy    = w_busy;
    assign done    = (r_state == DONE);

    for (genvar j = 0; j < COLS; j++) begin : g_w
        skew_line #(
            .DEPTH (j),
            .W     (DATA_W)
        ) u_skew (
            .clk     (clk),
            .rstn    (rstn),
            .i_flush (w_flush),
            .i_valid (w_v0),
            .i_data  (w_rdata[DATA_W*j +: DATA_W]),
            .o_data  (w_bus[DATA_W*j +: DATA_W])
        );
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_a
        skew_line #(
            .DEPTH (i),
            .W     (DATA_W)
        ) u_skew (
            .clk     (clk),
            .rstn    (rstn),
            .i_flush (w_flush),
            .i_valid (w_v0),
            .i_data  (a_rdata[DATA_W*i +: DATA_W]),
            .o_data  (a_bus[DATA_W*i +: DATA_W])
        );
    end

endmodule
